// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, tracks the one-cycle memory read
// latency and buffers up to two fetched words for decode behind valid/ready.
module imem_fetch_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] START_ADDR = 32'd0,
  parameter logic [31:0] LAST_ADDR  = 32'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [31:0]       imem_addr,
  input  logic [DATA_W-1:0] imem_inst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [31:0]       infl_pc_q, infl_pc_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] inst_q [2];
  logic [DATA_W-1:0] inst_d [2];
  logic [31:0]       bpc_q [2];
  logic [31:0]       bpc_d [2];

  logic pop;
  logic room;
  logic issue;
  logic pc_past_end;

  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & out_ready;
  // count + inflight never exceeds 2, so a free slot exists whenever the sum is below 2.
  assign room        = (({1'b0, count_q} + {2'b00, infl_q}) < 3'd2);
  assign pc_past_end = (pc_q > LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    count_d   = count_q;
    inst_d    = inst_q;
    bpc_d     = bpc_q;
    issue     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          infl_d  = 1'b0;
          count_d = 2'd0;
        end
      end

      RUN, DRAIN: begin
        if (redirect) begin
          // Redirect wins over issue, capture and pop: everything fetched so far is stale.
          pc_d    = redirect_pc;
          infl_d  = 1'b0;
          count_d = 2'd0;
          state_d = (redirect_pc > LAST_ADDR) ? DRAIN : RUN;
        end else begin
          if (state_q == RUN) begin
            if (pc_past_end) begin
              state_d = DRAIN;
            end else begin
              issue = room | pop;
            end
          end

          infl_d = issue;
          if (issue) begin
            infl_pc_d = pc_q;
            pc_d      = pc_q + 32'd1;
          end

          case ({infl_q, pop})
            2'b10: begin
              inst_d[count_q[0]] = imem_inst;
              bpc_d[count_q[0]]  = infl_pc_q;
              count_d            = count_q + 2'd1;
            end
            2'b01: begin
              inst_d[0] = inst_q[1];
              bpc_d[0]  = bpc_q[1];
              count_d   = count_q - 2'd1;
            end
            2'b11: begin
              if (count_q == 2'd1) begin
                inst_d[0] = imem_inst;
                bpc_d[0]  = infl_pc_q;
              end else begin
                inst_d[0] = inst_q[1];
                bpc_d[0]  = bpc_q[1];
                inst_d[1] = imem_inst;
                bpc_d[1]  = infl_pc_q;
              end
            end
            default: ;
          endcase

          if ((state_q == DRAIN) && (count_q == 2'd0) && !infl_q) begin
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    infl_pc_q <= infl_pc_d;
    inst_q    <= inst_d;
    bpc_q     <= bpc_d;
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      infl_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      count_q <= count_d;
    end
  end

  // Buffer data is not reset, so the head is masked to zero while empty.
  assign out_inst  = out_valid ? inst_q[0] : '0;
  assign out_pc    = out_valid ? bpc_q[0] : 32'd0;
  assign imem_addr = pc_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: scoreboard of expected PCs checked on
// every handshake, plus point checks of latency, stall, redirect and end of memory.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] LAST = 32'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        busy;
  logic        done;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb_pc [$];
  logic [31:0] max_addr = 32'd0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .DATA_W    (32),
    .START_ADDR(32'd0),
    .LAST_ADDR (LAST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .busy       (busy),
    .done       (done)
  );

  // Synchronous-read memory: word[n] = n + 0x100, one cycle after the address.
  always @(posedge clk) imem_inst <= imem_addr + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb_pc.push_back(32'(i));
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  // Handshake monitor: every accepted word must be the next expected PC/word.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (rst === 1'b0) begin
      if (imem_addr > max_addr) max_addr = imem_addr;
      if (out_valid === 1'b1 && out_ready === 1'b1 && redirect === 1'b0) begin
        checks++;
        assert (sb_pc.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=pc 0x%0h expected=no delivery", out_pc);
        end
        if (sb_pc.size() != 0) begin
          exp_pc = sb_pc.pop_front();
          chk("sb_pc", out_pc, exp_pc);
          chk("sb_inst", out_inst, exp_pc + 32'h100);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    out_ready   = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_inst",  out_inst, 32'd0);
    chk("rst_pc",    out_pc, 32'd0);
    rst = 1'b0;

    // Redirect in IDLE is ignored.
    redirect    = 1'b1;
    redirect_pc = 32'd5;
    tick();
    redirect = 1'b0;
    chk("idle_redir_addr", imem_addr, 32'd0);
    chk("idle_redir_busy", {31'd0, busy}, 32'd0);

    // Phase A: sustained streaming to end of memory.
    max_addr  = 32'd0;
    out_ready = 1'b1;
    push_range(0, 13);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy", {31'd0, busy}, 32'd1);
    chk("a_addr0", imem_addr, 32'd0);
    chk("a_valid_e0", {31'd0, out_valid}, 32'd0);
    tick();
    chk("a_valid_e1", {31'd0, out_valid}, 32'd0);
    tick();
    for (int k = 0; k <= 13; k++) begin
      chk("a_seq_valid", {31'd0, out_valid}, 32'd1);
      chk("a_seq_pc", out_pc, 32'(k));
      tick();
    end
    chk("a_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("a_drain_busy",  {31'd0, busy}, 32'd1);
    chk("a_drain_done",  {31'd0, done}, 32'd0);
    tick();
    chk("a_done",      {31'd0, done}, 32'd1);
    chk("a_busy_fall", {31'd0, busy}, 32'd0);
    chk("a_max_addr",  max_addr, 32'd14);
    chk("a_sb_empty",  32'(sb_pc.size()), 32'd0);

    // Phase B: back-pressure, two words buffered, start ignored while running.
    out_ready = 1'b0;
    push_range(0, 13);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("b_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("b_stall_pc",    out_pc, 32'd0);
      chk("b_stall_inst",  out_inst, 32'h100);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    chk("b_stall_addr", imem_addr, 32'd2);
    chk("b_stall_head", out_pc, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      chk("b_rel_valid", {31'd0, out_valid}, 32'd1);
      chk("b_rel_pc",    out_pc, 32'(k));
      tick();
    end
    wait_done("b_done", 60);
    chk("b_sb_empty", 32'(sb_pc.size()), 32'd0);

    // Phase C: redirect to 9 while pc 3 is buffered and pc 4 in flight.
    out_ready = 1'b1;
    push_range(0, 13);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("c_head_pc", out_pc, 32'd3);
    sb_pc.delete();
    push_range(9, 13);
    redirect    = 1'b1;
    redirect_pc = 32'd9;
    tick();
    redirect = 1'b0;
    chk("c_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("c_redir_addr",  imem_addr, 32'd9);
    chk("c_busy",        {31'd0, busy}, 32'd1);
    tick();
    chk("c_valid_r1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("c_valid_r2", {31'd0, out_valid}, 32'd1);
    chk("c_pc_r2",    out_pc, 32'd9);
    chk("c_inst_r2",  out_inst, 32'h109);
    wait_done("c_done", 40);
    chk("c_sb_empty", 32'(sb_pc.size()), 32'd0);

    // Phase D: redirect past the end of memory with a full buffer.
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("d_full_valid", {31'd0, out_valid}, 32'd1);
    chk("d_head_pc",    out_pc, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'd300;
    tick();
    redirect = 1'b0;
    chk("d_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("d_addr",        imem_addr, 32'd300);
    chk("d_busy",        {31'd0, busy}, 32'd1);
    chk("d_done_early",  {31'd0, done}, 32'd0);
    tick();
    chk("d_done",  {31'd0, done}, 32'd1);
    chk("d_idle_busy", {31'd0, busy}, 32'd0);

    // Phase E: restart from DONE, then reset mid-run with a full buffer.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e_addr", imem_addr, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    chk("e_restart_pc",   out_pc, 32'd0);
    chk("e_restart_inst", out_inst, 32'h100);
    tick();
    chk("e_full_addr", imem_addr, 32'd2);
    rst = 1'b1;
    tick();
    chk("e_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("e_rst_busy",  {31'd0, busy}, 32'd0);
    chk("e_rst_done",  {31'd0, done}, 32'd0);
    chk("e_rst_addr",  imem_addr, 32'd0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
